instruction_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter, issues word-aligned requests to instruction memory over a request/grant/response handshake, and buffers up to two returned instructions with their PCs in a small FIFO. Presents them to the decoder through a valid/ready interface; `instruction_o` drives the decoder's `instruction_i`. Handles control-flow redirects by flushing buffered and in-flight fetches.

---
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, credit-limited imem request/grant/response handshake,
// and a 2-entry {pc, instr} buffer feeding the decoder over valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0] pc_q;
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  discard_q;

  // In-order PCs of granted requests, consumed by every response (kept or dropped)
  logic [31:0] pcq_q [2];
  logic        pcq_rd_q, pcq_wr_q;

  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        fifo_rd_q, fifo_wr_q;
  logic [1:0]  fifo_cnt_q;

  logic grant, resp, drop, push, pop, credit;

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  // A response can only arrive into a free slot: outstanding + buffered never exceeds 2
  assign credit     = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < 3'd2;
  assign imem_req_o = rst_ni && credit;
  assign imem_addr_o = pc_q;

  assign instr_valid_o = (fifo_cnt_q != 2'd0);
  assign instruction_o = instr_valid_o ? fifo_instr_q[fifo_rd_q] : Nop;
  assign pc_o          = instr_valid_o ? fifo_pc_q[fifo_rd_q] : 32'h0;

  always_comb begin
    grant         = imem_req_o && imem_gnt_i;
    resp          = imem_rvalid_i && (outstanding_q != 2'd0);
    drop          = resp && (discard_q != 2'd0);
    push          = resp && !drop;
    pop           = instr_valid_o && instr_ready_i;
    outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, resp};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      pcq_rd_q      <= 1'b0;
      pcq_wr_q      <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      outstanding_q <= outstanding_d;
      if (grant) pcq_wr_q <= ~pcq_wr_q;
      if (resp)  pcq_rd_q <= ~pcq_rd_q;
      if (redirect_valid_i) begin
        // Everything still in flight after this edge belongs to the old stream
        pc_q       <= {redirect_pc_i[31:2], 2'b00};
        discard_q  <= outstanding_d;
        fifo_rd_q  <= 1'b0;
        fifo_wr_q  <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        if (drop)  discard_q <= discard_q - 2'd1;
        if (push)  fifo_wr_q <= ~fifo_wr_q;
        if (pop)   fifo_rd_q <= ~fifo_rd_q;
        fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) pcq_q[pcq_wr_q] <= pc_q;
    if (push && !redirect_valid_i) begin
      fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
      fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural memory with configurable latency
// and a scoreboard of expected {pc, instr} in fetch order.
module tb_instruction_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam logic [31:0] XorK  = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  instruction_fetch #(.RESET_PC(RstPc)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instruction_o   (instruction_o),
    .pc_o            (pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 0;
  req_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] hold_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_mem();
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = pend_q[0].addr ^ XorK;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
  endtask

  // One clock: sample handshakes at negedge, update memory/scoreboard just after posedge
  task automatic step();
    logic        g, rv, rd, pp;
    logic [31:0] a, e;
    @(negedge clk_i);
    g  = imem_req_o && imem_gnt_i;
    a  = imem_addr_o;
    rv = imem_rvalid_i;
    rd = redirect_valid_i;
    pp = instr_valid_o && instr_ready_i;
    if (pp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected no valid", pc_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", pc_o, e);
        check("pop_instr", instruction_o, e ^ XorK);
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (rv && pend_q.size() > 0) pend_q.delete(0);
    if (g) begin
      pend_q.push_back('{addr: a, due: cyc + lat});
      if (!rd) exp_q.push_back(a);
    end
    if (rd) exp_q.delete();
    drive_mem();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!instr_valid_o && k < 60) begin
      step();
      k++;
    end
    check(name, {31'b0, instr_valid_o}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = target;
    step();
    redirect_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
    check({tag, "_addr"}, imem_addr_o, RstPc);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    check({tag, "_instr"}, instruction_o, Nop);
    check({tag, "_pc"}, pc_o, 32'h0);
  endtask

  // Release reset just after an edge and expect first valid exactly two edges later
  task automatic boot(input string tag);
    rst_ni = 1'b1;
    #1;
    check({tag, "_req_after_release"}, {31'b0, imem_req_o}, 32'd1);
    check({tag, "_addr_after_release"}, imem_addr_o, RstPc);
    step();
    check({tag, "_valid_1cyc"}, {31'b0, instr_valid_o}, 32'd0);
    step();
    check({tag, "_valid_2cyc"}, {31'b0, instr_valid_o}, 32'd1);
    check({tag, "_first_pc"}, pc_o, RstPc);
    check({tag, "_first_instr"}, instruction_o, RstPc ^ XorK);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{target: 32'h0000_2003, exp_addr: 32'h0000_2000, exp_next: 32'h0000_2004};
    vecs[1] = '{target: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000};
    vecs[2] = '{target: 32'h0000_0041, exp_addr: 32'h0000_0040, exp_next: 32'h0000_0044};

    rst_ni           = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    imem_gnt_i       = 1'b1;
    imem_rvalid_i    = 1'b0;
    imem_rdata_i     = 32'h0;
    instr_ready_i    = 1'b1;
    #12;
    check_reset_outputs("reset");
    step();
    step();

    // Boot and stream
    boot("boot");
    repeat (16) step();

    // Backpressure: buffer fills, request drops, head holds
    instr_ready_i = 1'b0;
    step();
    hold_a = pc_o;
    repeat (10) begin
      step();
      check("bp_head_stable", pc_o, hold_a);
    end
    check("bp_req_low", {31'b0, imem_req_o}, 32'd0);
    check("bp_valid", {31'b0, instr_valid_o}, 32'd1);
    instr_ready_i = 1'b1;
    repeat (12) step();

    // Grant stall: request and address hold until granted
    imem_gnt_i = 1'b0;
    begin
      int k = 0;
      while (!imem_req_o && k < 20) begin
        step();
        k++;
      end
    end
    hold_a = imem_addr_o;
    repeat (3) begin
      step();
      check("stall_req", {31'b0, imem_req_o}, 32'd1);
      check("stall_addr", imem_addr_o, hold_a);
    end
    imem_gnt_i = 1'b1;
    step();
    check("stall_addr_after_gnt", imem_addr_o, hold_a + 32'd4);
    repeat (6) step();

    // Redirect with two requests in flight
    lat = 3;
    begin
      int k = 0;
      while (pend_q.size() != 2 && k < 40) begin
        step();
        k++;
      end
    end
    check("inflight_two", 32'(pend_q.size()), 32'd2);
    check("inflight_req_low", {31'b0, imem_req_o}, 32'd0);
    redirect(32'h0000_2000);
    check("rd2_addr", imem_addr_o, 32'h0000_2000);
    check("rd2_valid_low", {31'b0, instr_valid_o}, 32'd0);
    wait_valid("rd2_wait_valid");
    check("rd2_first_pc", pc_o, 32'h0000_2000);
    repeat (10) step();

    // Table of redirect targets with zero-wait memory
    lat = 0;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      redirect(vecs[i].target);
      check("vec_addr", imem_addr_o, vecs[i].exp_addr);
      check("vec_req", {31'b0, imem_req_o}, 32'd1);
      step();
      check("vec_next_addr", imem_addr_o, vecs[i].exp_next);
      wait_valid("vec_wait_valid");
      check("vec_first_pc", pc_o, vecs[i].exp_addr);
      repeat (5) step();
    end

    // Redirect coincident with a grant and a response
    begin
      int k = 0;
      while (!(imem_req_o && imem_rvalid_i) && k < 20) begin
        step();
        k++;
      end
      check("sim1_found", {31'b0, imem_req_o && imem_rvalid_i}, 32'd1);
    end
    redirect(32'h0000_2000);
    check("sim1_valid_low", {31'b0, instr_valid_o}, 32'd0);
    check("sim1_addr", imem_addr_o, 32'h0000_2000);
    wait_valid("sim1_wait_valid");
    check("sim1_first_pc", pc_o, 32'h0000_2000);

    // Redirect coincident with a grant and a pop
    begin
      int k = 0;
      while (!(imem_req_o && instr_valid_o) && k < 20) begin
        step();
        k++;
      end
      check("sim2_found", {31'b0, imem_req_o && instr_valid_o}, 32'd1);
    end
    redirect(32'h0000_3000);
    check("sim2_valid_low", {31'b0, instr_valid_o}, 32'd0);
    check("sim2_addr", imem_addr_o, 32'h0000_3000);
    wait_valid("sim2_wait_valid");
    check("sim2_first_pc", pc_o, 32'h0000_3000);
    repeat (4) step();

    // Async reset mid-burst with the buffer full
    instr_ready_i = 1'b0;
    repeat (6) step();
    check("pre_reset_full", {31'b0, instr_valid_o}, 32'd1);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    pend_q.delete();
    exp_q.delete();
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b1;
    step();
    step();
    boot("reboot");
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
